// File: rtl/tlul_reg_adapter.sv
// TL-UL device endpoint: converts single TL-UL transactions into a register
// strobe interface with wait states, timeout and malformed-request errors.

// Minimal TL-UL payload types shared with the crossbar sockets.
package tlul_pkg;
  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_AUW = 16;
  localparam int unsigned TL_DUW = 16;

  localparam logic [2:0] OpPutFullData    = 3'h0;
  localparam logic [2:0] OpPutPartialData = 3'h1;
  localparam logic [2:0] OpGet            = 3'h4;
  localparam logic [2:0] OpAccessAck      = 3'h0;
  localparam logic [2:0] OpAccessAckData  = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_AUW-1:0] a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_DUW-1:0] d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_reg_adapter #(
  parameter int unsigned RegAw         = 8,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [31:0]        wdata_o,
  output logic [3:0]         be_o,
  input  logic [31:0]        rdata_i,
  input  logic               busy_i,
  input  logic               error_i
);
  import tlul_pkg::*;

  localparam int unsigned CntRaw = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntW   = (CntRaw < 1) ? 1 : CntRaw;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e            state;
  logic              req_get;
  logic [CntW-1:0]   wait_cnt;
  logic              d_valid;
  logic              d_error;
  logic [2:0]        d_opcode;
  logic [TL_SZW-1:0] d_size;
  logic [TL_AIW-1:0] d_source;
  logic [31:0]       d_data;

  logic              malformed_c;
  logic              a_get_c;
  logic              timeout_hit_c;

  // Fields of the request that this endpoint has no use for.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:RegAw]};

  assign a_get_c = (tl_i.a_opcode == OpGet);

  // Request legality check on the incoming A-channel beat.
  always_comb begin
    malformed_c = 1'b0;
    case (tl_i.a_opcode)
      OpGet: malformed_c = 1'b0;
      OpPutFullData: begin
        if ((tl_i.a_size != 2'd2) || (tl_i.a_mask != 4'hF)) malformed_c = 1'b1;
      end
      OpPutPartialData: begin
        if (tl_i.a_mask == 4'h0) malformed_c = 1'b1;
      end
      default: malformed_c = 1'b1;
    endcase
    if (tl_i.a_address[1:0] != 2'b00) malformed_c = 1'b1;
    if (tl_i.a_size > 2'd2) malformed_c = 1'b1;
  end

  // This busy cycle would bring the wait count up to the timeout limit.
  assign timeout_hit_c = (TimeoutCycles != 0) &&
                         ((32'(wait_cnt) + 32'd1) == 32'(TimeoutCycles));

  // Transaction FSM with registered strobes and response fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= StIdle;
      req_get  <= 1'b0;
      wait_cnt <= '0;
      re_o     <= 1'b0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      be_o     <= '0;
      d_valid  <= 1'b0;
      d_error  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (tl_i.a_valid) begin
            req_get  <= a_get_c;
            addr_o   <= tl_i.a_address[RegAw-1:0];
            wdata_o  <= tl_i.a_data;
            be_o     <= tl_i.a_mask;
            d_size   <= tl_i.a_size;
            d_source <= tl_i.a_source;
            d_opcode <= a_get_c ? OpAccessAckData : OpAccessAck;
            if (malformed_c) begin
              state   <= StResp;
              d_valid <= 1'b1;
              d_error <= 1'b1;
              d_data  <= a_get_c ? 32'hFFFF_FFFF : 32'h0;
            end else begin
              state    <= StAccess;
              re_o     <= a_get_c;
              we_o     <= !a_get_c;
              wait_cnt <= '0;
            end
          end
        end
        StAccess: begin
          if (busy_i) begin
            if (timeout_hit_c) begin
              state   <= StResp;
              re_o    <= 1'b0;
              we_o    <= 1'b0;
              d_valid <= 1'b1;
              d_error <= 1'b1;
              d_data  <= req_get ? 32'hFFFF_FFFF : 32'h0;
            end else if (TimeoutCycles != 0) begin
              wait_cnt <= wait_cnt + CntW'(1);
            end
          end else begin
            state   <= StResp;
            re_o    <= 1'b0;
            we_o    <= 1'b0;
            d_valid <= 1'b1;
            d_error <= error_i;
            d_data  <= !req_get ? 32'h0 : (error_i ? 32'hFFFF_FFFF : rdata_i);
          end
        end
        StResp: begin
          if (tl_i.d_ready) begin
            state   <= StIdle;
            d_valid <= 1'b0;
            d_error <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          re_o  <= 1'b0;
          we_o  <= 1'b0;
        end
      endcase
    end
  end

  // D-channel and a_ready; a_ready is held low combinationally during reset.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = d_opcode;
    tl_o.d_size   = d_size;
    tl_o.d_source = d_source;
    tl_o.d_data   = d_data;
    tl_o.d_error  = d_error;
    tl_o.a_ready  = (state == StIdle) && !rst_i;
  end

endmodule
